// File: rtl/mem_stage.sv
// ============================================================================
//  Module      : mem_stage
//  Description : RV32 memory-access stage. Issues loads/stores over a req/ack
//                port, formats store lanes and load data, stalls upstream while
//                an access is outstanding, and registers MEM/WB outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_valid_inst,
  input  logic [31:0] ex_mem_alu_result,
  input  logic [31:0] ex_mem_regb,
  input  logic        ex_mem_rd_mem,
  input  logic        ex_mem_wr_mem,
  input  logic [2:0]  ex_mem_funct3,
  input  logic [4:0]  ex_mem_dest_reg,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_stall_out,
  output logic        mem_wb_valid_inst,
  output logic [31:0] mem_wb_result,
  output logic [4:0]  mem_wb_dest_reg,
  output logic        mem_wb_excp
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]  r_state;
  logic [0:0]  w_next_state;
  logic [31:0] r_cnt;
  logic [1:0]  r_addr_lo;
  logic [2:0]  r_funct3;
  logic [4:0]  r_dest;

  logic        w_memop, w_illegal, w_misal, w_go, w_fault;
  logic        w_timeout, w_done;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [31:0] w_sh, w_load;
  logic        w_wb_valid, w_wb_excp;
  logic [31:0] w_wb_result;
  logic [4:0]  w_wb_dest;

  // Classify the EX/MEM instruction: legal memops start an access, faults bypass
  always_comb begin
    w_memop   = ex_mem_rd_mem | ex_mem_wr_mem;
    w_illegal = (ex_mem_rd_mem & ex_mem_wr_mem)
              | (ex_mem_rd_mem & ((ex_mem_funct3 == 3'b011) | (ex_mem_funct3 == 3'b110) |
                                  (ex_mem_funct3 == 3'b111)))
              | (ex_mem_wr_mem & (ex_mem_funct3[2] | (ex_mem_funct3 == 3'b011)));
    w_misal   = ((ex_mem_funct3[1:0] == 2'b01) & ex_mem_alu_result[0])
              | ((ex_mem_funct3[1:0] == 2'b10) & (ex_mem_alu_result[1:0] != 2'b00));
    w_go      = ex_mem_valid_inst & w_memop & ~w_illegal & ~w_misal;
    w_fault   = ex_mem_valid_inst & w_memop & (w_illegal | w_misal);
  end

  // Replicate store data across lanes and build byte enables
  always_comb begin
    w_wdata = ex_mem_regb;
    w_wstrb = 4'b0000;
    if (ex_mem_wr_mem) begin
      case (ex_mem_funct3[1:0])
        2'b00: begin
          w_wdata = {4{ex_mem_regb[7:0]}};
          w_wstrb = 4'b0001 << ex_mem_alu_result[1:0];
        end
        2'b01: begin
          w_wdata = {2{ex_mem_regb[15:0]}};
          w_wstrb = 4'b0011 << ex_mem_alu_result[1:0];
        end
        default: begin
          w_wdata = ex_mem_regb;
          w_wstrb = 4'b1111;
        end
      endcase
    end
  end

  // Align and extend returned load data using the latched byte offset and size
  always_comb begin
    w_sh = mem_rdata >> {r_addr_lo, 3'b000};
    case (r_funct3)
      3'b000:  w_load = {{24{w_sh[7]}}, w_sh[7:0]};
      3'b100:  w_load = {24'd0, w_sh[7:0]};
      3'b001:  w_load = {{16{w_sh[15]}}, w_sh[15:0]};
      3'b101:  w_load = {16'd0, w_sh[15:0]};
      default: w_load = mem_rdata;
    endcase
  end

  // Timeout fires on the last allowed WAIT cycle without an ack
  always_comb begin
    w_timeout = (TIMEOUT_CYCLES != 0) && (r_state == ST_WAIT) && !mem_ack &&
                (r_cnt == (TIMEOUT_CYCLES - 32'd1));
    w_done    = (r_state == ST_WAIT) && (mem_ack || w_timeout);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_go) w_next_state = ST_WAIT;
      ST_WAIT: if (w_done) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs: upstream stall and the value the MEM/WB register will capture
  always_comb begin
    mem_stall_out = 1'b0;
    w_wb_valid    = 1'b0;
    w_wb_result   = 32'd0;
    w_wb_dest     = 5'd0;
    w_wb_excp     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        mem_stall_out = w_go;
        if (!w_go) begin
          w_wb_valid  = ex_mem_valid_inst;
          w_wb_result = w_fault ? 32'd0 : ex_mem_alu_result;
          w_wb_dest   = ex_mem_dest_reg;
          w_wb_excp   = w_fault;
        end
      end
      ST_WAIT: begin
        mem_stall_out = !w_done;
        if (mem_ack) begin
          w_wb_valid  = 1'b1;
          w_wb_result = mem_we ? 32'd0 : w_load;
          w_wb_dest   = r_dest;
        end else if (w_timeout) begin
          w_wb_valid  = 1'b1;
          w_wb_dest   = r_dest;
          w_wb_excp   = 1'b1;
        end
      end
      default: mem_stall_out = 1'b0;
    endcase
    // Never stall while reset holds the stage idle
    if (rst) mem_stall_out = 1'b0;
  end

  // Request register, access context and wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wstrb <= 4'b0000;
      r_addr_lo <= 2'b00;
      r_funct3  <= 3'b000;
      r_dest    <= 5'd0;
      r_cnt     <= 32'd0;
    end else if (r_state == ST_IDLE) begin
      if (w_go) begin
        mem_req   <= 1'b1;
        mem_we    <= ex_mem_wr_mem;
        mem_addr  <= {ex_mem_alu_result[31:2], 2'b00};
        mem_wdata <= w_wdata;
        mem_wstrb <= w_wstrb;
        r_addr_lo <= ex_mem_alu_result[1:0];
        r_funct3  <= ex_mem_funct3;
        r_dest    <= ex_mem_dest_reg;
        r_cnt     <= 32'd0;
      end
    end else begin
      if (w_done) mem_req <= 1'b0;
      else        r_cnt   <= r_cnt + 32'd1;
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wb_valid_inst <= 1'b0;
      mem_wb_result     <= 32'd0;
      mem_wb_dest_reg   <= 5'd0;
      mem_wb_excp       <= 1'b0;
    end else begin
      mem_wb_valid_inst <= w_wb_valid;
      mem_wb_result     <= w_wb_result;
      mem_wb_dest_reg   <= w_wb_dest;
      mem_wb_excp       <= w_wb_excp;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Directed self-checking bench for mem_stage (TIMEOUT_CYCLES=4)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_mem_valid_inst = 1'b0;
  logic [31:0] ex_mem_alu_result = 32'd0;
  logic [31:0] ex_mem_regb = 32'd0;
  logic        ex_mem_rd_mem = 1'b0;
  logic        ex_mem_wr_mem = 1'b0;
  logic [2:0]  ex_mem_funct3 = 3'd0;
  logic [4:0]  ex_mem_dest_reg = 5'd0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_stall_out, mem_wb_valid_inst, mem_wb_excp;
  logic [31:0] mem_wb_result;
  logic [4:0]  mem_wb_dest_reg;

  int n_pass  = 0;
  int n_total = 0;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .ex_mem_valid_inst(ex_mem_valid_inst), .ex_mem_alu_result(ex_mem_alu_result),
    .ex_mem_regb(ex_mem_regb), .ex_mem_rd_mem(ex_mem_rd_mem),
    .ex_mem_wr_mem(ex_mem_wr_mem), .ex_mem_funct3(ex_mem_funct3),
    .ex_mem_dest_reg(ex_mem_dest_reg),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_stall_out(mem_stall_out), .mem_wb_valid_inst(mem_wb_valid_inst),
    .mem_wb_result(mem_wb_result), .mem_wb_dest_reg(mem_wb_dest_reg),
    .mem_wb_excp(mem_wb_excp)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] regb,
                          input logic [4:0] dest);
    ex_mem_valid_inst = 1'b1;
    ex_mem_rd_mem     = rd;
    ex_mem_wr_mem     = wr;
    ex_mem_funct3     = f3;
    ex_mem_alu_result = addr;
    ex_mem_regb       = regb;
    ex_mem_dest_reg   = dest;
    #1;
  endtask

  task automatic drive_idle();
    ex_mem_valid_inst = 1'b0;
    ex_mem_rd_mem     = 1'b0;
    ex_mem_wr_mem     = 1'b0;
    ex_mem_funct3     = 3'd0;
    ex_mem_alu_result = 32'd0;
    ex_mem_regb       = 32'd0;
    ex_mem_dest_reg   = 5'd0;
    mem_ack           = 1'b0;
    mem_rdata         = 32'd0;
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_total++; if (mem_req !== 1'b0) $display("FAIL rst_req got %0b exp 0", mem_req); else n_pass++;
    n_total++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_wstrb !== 4'd0 || mem_we !== 1'b0)
      $display("FAIL rst_reqfields got %h %h %h %b exp 0", mem_addr, mem_wdata, mem_wstrb, mem_we); else n_pass++;
    n_total++; if ({mem_wb_valid_inst, mem_wb_excp, mem_stall_out} !== 3'b000 || mem_wb_result !== 32'd0 || mem_wb_dest_reg !== 5'd0)
      $display("FAIL rst_wb got v%b e%b s%b %h %0d exp 0", mem_wb_valid_inst, mem_wb_excp, mem_stall_out, mem_wb_result, mem_wb_dest_reg); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_passthrough();
    drive_op(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 5'd7);
    n_total++; if (mem_stall_out !== 1'b0) $display("FAIL pt_stall got %0b exp 0", mem_stall_out); else n_pass++;
    tick();
    drive_idle();
    n_total++; if (mem_wb_valid_inst !== 1'b1 || mem_wb_excp !== 1'b0) $display("FAIL pt_flags got v%b e%b exp v1 e0", mem_wb_valid_inst, mem_wb_excp); else n_pass++;
    n_total++; if (mem_wb_result !== 32'h1234_5678) $display("FAIL pt_result got %h exp 12345678", mem_wb_result); else n_pass++;
    n_total++; if (mem_wb_dest_reg !== 5'd7) $display("FAIL pt_dest got %0d exp 7", mem_wb_dest_reg); else n_pass++;
    n_total++; if (mem_req !== 1'b0) $display("FAIL pt_req got %0b exp 0", mem_req); else n_pass++;
  endtask

  // LB then LBU back to back at 0x103, each acked on its third request cycle
  task automatic test_back_to_back();
    int stalls;
    drive_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd3);
    stalls = 0;
    for (int c = 0; c < 3; c++) begin
      if (mem_stall_out === 1'b1) stalls++;
      if (c == 0) begin
        n_total++; if (mem_req !== 1'b0) $display("FAIL lb_req_t0 got %0b exp 0", mem_req); else n_pass++;
      end
      tick();
      n_total++; if (mem_wb_valid_inst !== 1'b0) $display("FAIL lb_bubble%0d got %0b exp 0", c, mem_wb_valid_inst); else n_pass++;
    end
    n_total++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100 || mem_wstrb !== 4'b0000)
      $display("FAIL lb_req got r%b w%b %h %b exp r1 w0 00000100 0000", mem_req, mem_we, mem_addr, mem_wstrb); else n_pass++;
    mem_ack = 1'b1; mem_rdata = 32'h80FF_0000; #1;
    n_total++; if (mem_stall_out !== 1'b0) $display("FAIL lb_stall_ack got %0b exp 0", mem_stall_out); else n_pass++;
    n_total++; if (stalls != 3) $display("FAIL lb_stall_cycles got %0d exp 3", stalls); else n_pass++;
    tick();
    mem_ack = 1'b0;
    drive_op(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 5'd4);
    n_total++; if (mem_wb_valid_inst !== 1'b1 || mem_wb_result !== 32'hFFFF_FF80 || mem_wb_dest_reg !== 5'd3 || mem_wb_excp !== 1'b0)
      $display("FAIL lb_result got v%b %h d%0d e%b exp v1 ffffff80 d3 e0", mem_wb_valid_inst, mem_wb_result, mem_wb_dest_reg, mem_wb_excp); else n_pass++;
    n_total++; if (mem_req !== 1'b0) $display("FAIL b2b_gap got %0b exp 0", mem_req); else n_pass++;
    n_total++; if (mem_stall_out !== 1'b1) $display("FAIL lbu_stall got %0b exp 1", mem_stall_out); else n_pass++;
    tick();
    n_total++; if (mem_req !== 1'b1) $display("FAIL lbu_req got %0b exp 1", mem_req); else n_pass++;
    tick();
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h80FF_0000; #1;
    tick();
    drive_idle();
    n_total++; if (mem_wb_valid_inst !== 1'b1 || mem_wb_result !== 32'h0000_0080 || mem_wb_dest_reg !== 5'd4)
      $display("FAIL lbu_result got v%b %h d%0d exp v1 00000080 d4", mem_wb_valid_inst, mem_wb_result, mem_wb_dest_reg); else n_pass++;
  endtask

  task automatic test_store();
    drive_op(1'b0, 1'b1, 3'b001, 32'h0000_0022, 32'hDEAD_BEEF, 5'd9);
    tick();
    n_total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h20)
      $display("FAIL sh_req got r%b w%b %h exp r1 w1 00000020", mem_req, mem_we, mem_addr); else n_pass++;
    n_total++; if (mem_wdata !== 32'hBEEF_BEEF || mem_wstrb !== 4'b1100)
      $display("FAIL sh_data got %h %b exp beefbeef 1100", mem_wdata, mem_wstrb); else n_pass++;
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555; #1;
    tick();
    drive_op(1'b0, 1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 5'd2);
    n_total++; if (mem_wb_valid_inst !== 1'b1 || mem_wb_result !== 32'd0 || mem_wb_excp !== 1'b0)
      $display("FAIL sh_result got v%b %h e%b exp v1 0 e0", mem_wb_valid_inst, mem_wb_result, mem_wb_excp); else n_pass++;
    tick();
    mem_ack = 1'b1; #1;
    n_total++; if (mem_wdata !== 32'hA5A5_A5A5 || mem_wstrb !== 4'b1000 || mem_addr !== 32'h10)
      $display("FAIL sb_data got %h %b %h exp a5a5a5a5 1000 00000010", mem_wdata, mem_wstrb, mem_addr); else n_pass++;
    tick();
    drive_idle();
  endtask

  task automatic test_faults();
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 5'd5);
    n_total++; if (mem_stall_out !== 1'b0) $display("FAIL mis_stall got %0b exp 0", mem_stall_out); else n_pass++;
    tick();
    drive_op(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 5'd6);
    n_total++; if (mem_req !== 1'b0) $display("FAIL mis_req got %0b exp 0", mem_req); else n_pass++;
    n_total++; if (mem_wb_valid_inst !== 1'b1 || mem_wb_excp !== 1'b1 || mem_wb_result !== 32'd0)
      $display("FAIL mis_wb got v%b e%b %h exp v1 e1 0", mem_wb_valid_inst, mem_wb_excp, mem_wb_result); else n_pass++;
    tick();
    drive_idle();
    n_total++; if (mem_wb_excp !== 1'b1 || mem_wb_dest_reg !== 5'd6 || mem_req !== 1'b0)
      $display("FAIL ill_wb got e%b d%0d r%b exp e1 d6 r0", mem_wb_excp, mem_wb_dest_reg, mem_req); else n_pass++;
  endtask

  task automatic test_timeout();
    int stalls;
    int bubbles;
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd8);
    stalls = 0;
    bubbles = 0;
    for (int c = 0; c < 4; c++) begin
      if (mem_stall_out === 1'b1) stalls++;
      tick();
      if (mem_wb_valid_inst === 1'b0 && mem_wb_excp === 1'b0) bubbles++;
    end
    n_total++; if (stalls != 4) $display("FAIL to_stall_cycles got %0d exp 4", stalls); else n_pass++;
    n_total++; if (bubbles != 4) $display("FAIL to_bubbles got %0d exp 4", bubbles); else n_pass++;
    n_total++; if (mem_stall_out !== 1'b0 || mem_req !== 1'b1)
      $display("FAIL to_last got s%b r%b exp s0 r1", mem_stall_out, mem_req); else n_pass++;
    tick();
    drive_idle();
    n_total++; if (mem_req !== 1'b0 || mem_wb_valid_inst !== 1'b1 || mem_wb_excp !== 1'b1 || mem_wb_result !== 32'd0)
      $display("FAIL to_abort got r%b v%b e%b %h exp r0 v1 e1 0", mem_req, mem_wb_valid_inst, mem_wb_excp, mem_wb_result); else n_pass++;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF; #1;
    n_total++; if (mem_stall_out !== 1'b0) $display("FAIL late_ack_stall got %0b exp 0", mem_stall_out); else n_pass++;
    tick();
    mem_ack = 1'b0;
    n_total++; if (mem_req !== 1'b0 || mem_wb_valid_inst !== 1'b0 || mem_wb_excp !== 1'b0)
      $display("FAIL late_ack got r%b v%b e%b exp r0 v0 e0", mem_req, mem_wb_valid_inst, mem_wb_excp); else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd10);
    tick();
    n_total++; if (mem_req !== 1'b1) $display("FAIL mr_req_pre got %0b exp 1", mem_req); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++; if (mem_req !== 1'b0 || mem_stall_out !== 1'b0)
      $display("FAIL mr_async got r%b s%b exp r0 s0", mem_req, mem_stall_out); else n_pass++;
    drive_idle();
    tick();
    rst = 1'b0;
    drive_op(1'b0, 1'b0, 3'b000, 32'hCAFE_0001, 32'h0, 5'd11);
    n_total++; if (mem_stall_out !== 1'b0) $display("FAIL mr_pt_stall got %0b exp 0", mem_stall_out); else n_pass++;
    tick();
    drive_idle();
    n_total++; if (mem_wb_valid_inst !== 1'b1 || mem_wb_result !== 32'hCAFE_0001 || mem_wb_dest_reg !== 5'd11 || mem_req !== 1'b0)
      $display("FAIL mr_pt got v%b %h d%0d r%b exp v1 cafe0001 d11 r0", mem_wb_valid_inst, mem_wb_result, mem_wb_dest_reg, mem_req); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_back_to_back();
    test_store();
    test_faults();
    test_timeout();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the in-order RV32 pipeline, directly downstream of `ex_stage`. It takes the EX/MEM-registered ALU result as the effective address, runs loads and stores over a req/ack data-memory port, aligns and extends load data, and registers the MEM/WB outputs. While a memory access is outstanding it stalls the upstream pipeline. Non-memory instructions pass through with one cycle of latency.

## Interface
- `TIMEOUT_CYCLES`, default 0: number of WAIT cycles without `mem_ack` before the access is aborted; 0 disables the timeout.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `ex_mem_valid_inst` in 1: EX/MEM slot holds a valid instruction.
- `ex_mem_alu_result` in 32: ALU result; this is the address for loads and stores.
- `ex_mem_regb` in 32: store data (rs2).
- `ex_mem_rd_mem` in 1: instruction is a load.
- `ex_mem_wr_mem` in 1: instruction is a store.
- `ex_mem_funct3` in 3: access size and signedness.
- `ex_mem_dest_reg` in 5: destination register index.
- `mem_req` out 1: memory request, registered.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: word-aligned address, with `[1:0]` = 0.
- `mem_wdata` out 32: lane-replicated write data.
- `mem_wstrb` out 4: byte write enables.
- `mem_ack` in 1: access complete; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: read word.
- `mem_stall_out` out 1: hold EX/MEM and all earlier stages; combinational.
- `mem_wb_valid_inst` out 1: MEM/WB slot valid.
- `mem_wb_result` out 32: load data or pass-through ALU result.
- `mem_wb_dest_reg` out 5: destination register index.
- `mem_wb_excp` out 1: misaligned, illegal, or timed-out access.

## Operation
- **Op classification** (when `ex_mem_valid_inst` = 1):
  - memop = `rd_mem | wr_mem`.
  - illegal when `rd_mem & wr_mem`, when a load has funct3 ∈ {011, 110, 111}, or when a store has `funct3[2]` = 1 or funct3 = 011.
  - misaligned when a halfword access has `addr[0]` = 1, or a word access has `addr[1:0]` ≠ 0.
- **FSM states:** IDLE and WAIT.
- **IDLE, legal aligned memop:**
  - `mem_stall_out` = 1.
  - At the next edge: go to WAIT; latch `mem_req` = 1, `mem_we` = `wr_mem`, `mem_addr` = `{addr[31:2], 2'b00}`, `mem_wdata`, `mem_wstrb`; latch `addr[1:0]` and funct3 internally; clear the timeout counter.
- **IDLE, non-memop / illegal / misaligned / invalid:**
  - No request; `mem_stall_out` = 0.
  - The MEM/WB register captures:
    - valid = `ex_mem_valid_inst`;
    - result = `ex_mem_alu_result` for non-memops, 0 for faults;
    - excp = 1 for faults only.
- **WAIT:**
  - `mem_req` is held and all request fields are stable.
  - While no ack: `mem_stall_out` = 1; MEM/WB captures a bubble (valid = 0, excp = 0); the counter increments.
  - On the `mem_ack` cycle: `mem_stall_out` = 0. At the edge: `mem_req` = 0, return to IDLE, and MEM/WB captures valid = 1, dest, and result (formatted load data; 0 for stores).
- **Timeout** (`TIMEOUT_CYCLES` > 0): if the counter equals `TIMEOUT_CYCLES`−1 and `mem_ack` = 0:
  - `mem_stall_out` = 0.
  - At the edge: `mem_req` = 0, return to IDLE, MEM/WB gets valid = 1, result = 0, excp = 1.
  - A later ack is ignored.
- **Store formatting:**
  - SB: `wdata = {4{regb[7:0]}}`, `wstrb = 4'b0001 << addr[1:0]`.
  - SH: `wdata = {2{regb[15:0]}}`, `wstrb = 4'b0011 << addr[1:0]`.
  - SW: `wdata = regb`, `wstrb = 4'b1111`.
  - Loads drive `wstrb` = 0.
- **Load formatting:**
  - Compute `sh = mem_rdata >> (8*addr[1:0])`.
  - LB sign-extends `sh[7:0]`; LBU zero-extends `sh[7:0]`.
  - LH sign-extends `sh[15:0]`; LHU zero-extends `sh[15:0]`.
  - LW returns `mem_rdata`.
- `mem_ack` in IDLE is ignored.

## Timing
- **Reset values:** all outputs 0 (`mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`, `mem_wb_*`, `mem_stall_out`); state = IDLE; counter = 0.
- **Reset mid-access:** `mem_req` drops asynchronously and the access is abandoned.
- **Non-memop:** presented in cycle T, appears at MEM/WB in T+1, with no stall.
- **Memop:** presented in cycle T with ack in cycle T+k (k ≥ 1):
  - `mem_req` is high over T+1..T+k;
  - `mem_stall_out` is high over T..T+k−1;
  - the result appears at MEM/WB in T+k+1.
  - The minimum memop latency is 2 cycles.
- **Upstream contract:** the upstream stage holds all `ex_mem_*` inputs stable while `mem_stall_out` = 1. The stage samples them only in IDLE.
- **Back-to-back memops:** the next op is presented in T+k+1 and its `mem_req` rises in T+k+2. This leaves one `mem_req` = 0 cycle between accesses.

## Test plan
- **Pass-through:** valid ALU op with result 0x1234_5678, dest 7 → next cycle MEM/WB valid = 1, result 0x1234_5678, dest 7, excp = 0, no stall.
- **LB sign/zero:** address 0x103, ack after 3 WAIT cycles with rdata 0x80FF_0000 → `mem_addr` 0x100; stall for 3 cycles; LB result 0xFFFF_FF80; LBU result 0x0000_0080.
- **SH at address 0x22:** regb 0xDEAD_BEEF → `mem_we` = 1, `mem_addr` 0x20, `mem_wdata` 0xBEEF_BEEF, `mem_wstrb` 4'b1100; result 0 after ack.
- **Misaligned LW at 0x101:** → `mem_req` never rises, no stall; next cycle valid = 1, excp = 1, result 0.
- **Timeout:** `TIMEOUT_CYCLES` = 4, no ack → stall high for 4 cycles and bubbles at MEM/WB; then excp = 1 and `mem_req` low; an ack arriving 2 cycles later has no effect.
- **Reset during WAIT:** assert `rst` mid-access → `mem_req` and `mem_stall_out` go to 0 immediately; after release, an ALU op passes through normally.
